// File: rtl/seven_seg_mux.sv
// seven_seg_mux: two-digit time-multiplexed seven-segment driver.
// Shows s1 on digit 0 and s2 on digit 1 over one shared active-low segment
// bus, and shows the adder sum on five LEDs. s1, s2 and sum are captured once
// per frame, at the transition into DIG0, so a digit never changes mid-frame.
// Optional feature: define SEVEN_SEG_MUX_BLANK_EN to add a dark dead-time
// state after each digit, which suppresses ghosting. If the macro is
// undefined, the FSM alternates DIG0/DIG1 and BLANK_CYCLES only sizes the
// dwell counter.
module seven_seg_mux #(
   parameter int REFRESH_DIV  = 24000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] s1,
   input  logic [3:0] s2,
   input  logic [4:0] sum,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic [4:0] led
);

   localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(REFRESH_DIV - 1);

   localparam logic [6:0] SEG_DARK = 7'b1111111;
   localparam logic [1:0] AN_DARK  = 2'b11;
   localparam logic [1:0] AN_DIG0  = 2'b10;
   localparam logic [1:0] AN_DIG1  = 2'b01;

`ifdef SEVEN_SEG_MUX_BLANK_EN
   typedef enum logic [1:0] {
      DIG0   = 2'd0,
      BLANK0 = 2'd1,
      DIG1   = 2'd2,
      BLANK1 = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   // Reset parks the FSM at the start of the last dead time. The first
   // capture therefore happens BLANK_CYCLES cycles after release.
   localparam state_t           RESET_STATE = BLANK1;
   localparam logic [CNT_W-1:0] RESET_CNT   = CNT_ZERO;
`else
   typedef enum logic [0:0] {
      DIG0 = 1'b0,
      DIG1 = 1'b1
   } state_t;

   // Reset parks the FSM in the last cycle of DIG1. The first capture and
   // DIG0 therefore start one cycle after release.
   localparam state_t           RESET_STATE = DIG1;
   localparam logic [CNT_W-1:0] RESET_CNT   = DIG_LAST;
`endif

   // Active-low hex decoder, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] dec7(input logic [3:0] v);
      logic [6:0] r;
      case (v)
         4'h0:    r = 7'b1000000;
         4'h1:    r = 7'b1111001;
         4'h2:    r = 7'b0100100;
         4'h3:    r = 7'b0110000;
         4'h4:    r = 7'b0011001;
         4'h5:    r = 7'b0010010;
         4'h6:    r = 7'b0000010;
         4'h7:    r = 7'b1111000;
         4'h8:    r = 7'b0000000;
         4'h9:    r = 7'b0010000;
         4'hA:    r = 7'b0001000;
         4'hB:    r = 7'b0000011;
         4'hC:    r = 7'b1000110;
         4'hD:    r = 7'b0100001;
         4'hE:    r = 7'b0000110;
         4'hF:    r = 7'b0001110;
         default: r = SEG_DARK;
      endcase
      return r;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       cap_s1_q, cap_s1_d;
   logic [3:0]       cap_s2_q, cap_s2_d;
   logic [4:0]       led_q, led_d;
   logic [6:0]       seg_q, seg_d;
   logic [1:0]       an_q, an_d;
   logic             capture_s;

   // State, dwell counter, frame capture and output registers, with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RESET_STATE;
         cnt_q    <= RESET_CNT;
         cap_s1_q <= 4'h0;
         cap_s2_q <= 4'h0;
         led_q    <= 5'b00000;
         seg_q    <= SEG_DARK;
         an_q     <= AN_DARK;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cap_s1_q <= cap_s1_d;
         cap_s2_q <= cap_s2_d;
         led_q    <= led_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
      end
   end

   // Next state and dwell counter; flags the capture on entry into DIG0.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_ONE;
      capture_s = 1'b0;
      case (state_q)
`ifdef SEVEN_SEG_MUX_BLANK_EN
         DIG0: begin
            if (cnt_q == DIG_LAST) begin
               state_d = BLANK0;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = DIG0;
            end
         end
         BLANK0: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = DIG1;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = BLANK0;
            end
         end
         DIG1: begin
            if (cnt_q == DIG_LAST) begin
               state_d = BLANK1;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = DIG1;
            end
         end
         BLANK1: begin
            if (cnt_q == BLANK_LAST) begin
               state_d   = DIG0;
               cnt_d     = CNT_ZERO;
               capture_s = 1'b1;
            end else begin
               state_d = BLANK1;
            end
         end
`else
         DIG0: begin
            if (cnt_q == DIG_LAST) begin
               state_d = DIG1;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = DIG0;
            end
         end
         DIG1: begin
            if (cnt_q == DIG_LAST) begin
               state_d   = DIG0;
               cnt_d     = CNT_ZERO;
               capture_s = 1'b1;
            end else begin
               state_d = DIG1;
            end
         end
`endif
         default: begin
            state_d = RESET_STATE;
            cnt_d   = RESET_CNT;
         end
      endcase
   end

   // Frame capture of the operands and sum; holds them between capture edges.
   always_comb begin
      if (capture_s) begin
         cap_s1_d = s1;
         cap_s2_d = s2;
         led_d    = sum;
      end else begin
         cap_s1_d = cap_s1_q;
         cap_s2_d = cap_s2_q;
         led_d    = led_q;
      end
   end

   // Digit enable and segments for the current state. These are registered,
   // so they appear one cycle later. Every state outside a digit is dark.
   always_comb begin
      seg_d = SEG_DARK;
      an_d  = AN_DARK;
      case (state_q)
         DIG0: begin
            an_d  = AN_DIG0;
            seg_d = dec7(cap_s1_q);
         end
         DIG1: begin
            an_d  = AN_DIG1;
            seg_d = dec7(cap_s2_q);
         end
         default: begin
            an_d  = AN_DARK;
            seg_d = SEG_DARK;
         end
      endcase
   end

   assign seg = seg_q;
   assign an  = an_q;
   assign led = led_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Randomized self-checking bench for seven_seg_mux with REFRESH_DIV=4 and
// BLANK_CYCLES=2. The reference model tracks the position inside the frame
// with plain modular arithmetic. Define SEVEN_SEG_MUX_BLANK_EN to build and
// check the dead-time variant.
module tb_seven_seg_mux;

   localparam int R = 4;
   localparam int B = 2;
`ifdef SEVEN_SEG_MUX_BLANK_EN
   localparam int FRAME = 2 * (R + B);
   localparam int START = FRAME - B;   // reset lands at the start of the last dead time
`else
   localparam int FRAME = 2 * R;
   localparam int START = FRAME - 1;   // reset lands in the last cycle of digit 1
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] s1, s2;
   logic [4:0] sum;
   logic [6:0] seg;
   logic [1:0] an;
   logic [4:0] led;

   always #5 clk = ~clk;

   seven_seg_mux #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
      .clk   (clk),
      .reset (reset),
      .s1    (s1),
      .s2    (s2),
      .sum   (sum),
      .seg   (seg),
      .an    (an),
      .led   (led)
   );

   int checks = 0;
   int errors = 0;

   logic [6:0] hex_tbl [16];

   // Reference model state
   int         n;        // clock edges since the reset edge
   logic [3:0] m_s1, m_s2;
   logic [4:0] m_led;
   logic [6:0] exp_seg;
   logic [1:0] exp_an;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int fpos();
      return (START + n) % FRAME;
   endfunction

   // Returns 0 for digit 0, 1 for digit 1 and 2 for dark, at frame position p.
   function automatic int which_digit(input int p);
`ifdef SEVEN_SEG_MUX_BLANK_EN
      if (p < R)              return 0;
      else if (p < R + B)     return 2;
      else if (p < 2 * R + B) return 1;
      else                    return 2;
`else
      return (p < R) ? 0 : 1;
`endif
   endfunction

   // One clock: drive the inputs, advance the model at the edge, and check after the edge.
   task automatic step(input logic rst, input logic [3:0] a, input logic [3:0] b, input logic [4:0] c);
      int d;
      reset = rst; s1 = a; s2 = b; sum = c;
      @(posedge clk);
      if (rst) begin
         n = 0; m_s1 = 4'h0; m_s2 = 4'h0; m_led = 5'b00000;
         exp_seg = 7'b1111111; exp_an = 2'b11;
      end else begin
         d = which_digit(fpos());
         if (d == 0) begin
            exp_an = 2'b10; exp_seg = hex_tbl[m_s1];
         end else if (d == 1) begin
            exp_an = 2'b01; exp_seg = hex_tbl[m_s2];
         end else begin
            exp_an = 2'b11; exp_seg = 7'b1111111;
         end
         n++;
         if (fpos() == 0) begin
            m_s1 = a; m_s2 = b; m_led = c;
         end
      end
      #2;
      chk("seg", 32'(seg), 32'(exp_seg));
      chk("an", 32'(an), 32'(exp_an));
      chk("led", 32'(led), 32'(m_led));
      chk("an_never_00", 32'(an == 2'b00), 32'd0);
      if (an == 2'b11) chk("dark_seg", 32'(seg), 32'h7F);
      @(negedge clk);
   endtask

   initial begin
      hex_tbl[0]  = 7'b1000000; hex_tbl[1]  = 7'b1111001;
      hex_tbl[2]  = 7'b0100100; hex_tbl[3]  = 7'b0110000;
      hex_tbl[4]  = 7'b0011001; hex_tbl[5]  = 7'b0010010;
      hex_tbl[6]  = 7'b0000010; hex_tbl[7]  = 7'b1111000;
      hex_tbl[8]  = 7'b0000000; hex_tbl[9]  = 7'b0010000;
      hex_tbl[10] = 7'b0001000; hex_tbl[11] = 7'b0000011;
      hex_tbl[12] = 7'b1000110; hex_tbl[13] = 7'b0100001;
      hex_tbl[14] = 7'b0000110; hex_tbl[15] = 7'b0001110;
      n = 0; m_s1 = 4'h0; m_s2 = 4'h0; m_led = 5'b00000;
      exp_seg = 7'b1111111; exp_an = 2'b11;
      reset = 1'b1; s1 = 4'h5; s2 = 4'h0; sum = 5'b00000;
      @(negedge clk);

      // Reset held for three cycles with s1 = 5, then release with 5 still applied.
      repeat (3) step(1'b1, 4'h5, 4'h0, 5'b00000);
      repeat (B + R + 1) step(1'b0, 4'h5, 4'h0, 5'b00000);

      // Steady display of 3 / A with sum 01101.
      repeat (2 * FRAME + 3) step(1'b0, 4'h3, 4'hA, 5'b01101);

      // Mid-frame change: s2 changes to F while digit 0 is lit.
      for (int k = 0; k < 2 * FRAME && which_digit(fpos()) != 0; k++)
         step(1'b0, 4'h3, 4'hA, 5'b01101);
      repeat (2 * FRAME + 2) step(1'b0, 4'h3, 4'hF, 5'b01101);

      // Random inputs every cycle, with occasional resets.
      for (int k = 0; k < 1000; k++) begin
         step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              5'($urandom_range(0, 31)));
      end

      // Reset while digit 1 is lit, with 8 / 1 / 01001 applied.
      for (int k = 0; k < 2 * FRAME && which_digit(fpos()) != 1; k++)
         step(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
      step(1'b1, 4'h8, 4'h1, 5'b01001);
      repeat (2 * FRAME + 2) step(1'b0, 4'h8, 4'h1, 5'b01001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seven_seg_mux.md
# seven_seg_mux

Time-multiplexed two-digit seven-segment driver downstream of `five_bit_adder`. It consumes the same two 4-bit operands and the 5-bit sum the adder produces. It shows `s1` on digit 0 and `s2` on digit 1 through one shared segment bus, and registers the sum onto five LEDs. All inputs are captured once per frame so the display never tears mid-frame.

## Interface
- Reset is synchronous, active-high; single clock domain.
- Parameters:
  - `REFRESH_DIV`, default 24000: cycles each digit is lit; legal range ≥ 2.
  - `BLANK_CYCLES`, default 16: dead-time cycles after each digit; legal range ≥ 1; used only when the blanking feature is compiled in.
- Ports:
  - `clk` in, 1: system clock.
  - `reset` in, 1: synchronous, active-high.
  - `s1` in, 4: operand shown on digit 0.
  - `s2` in, 4: operand shown on digit 1.
  - `sum` in, 5: adder result.
  - `seg` out, 7: `{g,f,e,d,c,b,a}`, active-low.
  - `an` out, 2: digit enables, active-low; `an[0]` is digit 0, `an[1]` is digit 1.
  - `led` out, 5: registered sum, active-high.

## Operation
- FSM states: `DIG0`, `BLANK0`, `DIG1`, `BLANK1`. One dwell counter, width `$clog2(max(REFRESH_DIV,BLANK_CYCLES))`.
- Transitions:
  - `DIG0` → `BLANK0` after `REFRESH_DIV` cycles.
  - `BLANK0` → `DIG1` after `BLANK_CYCLES` cycles.
  - `DIG1` → `BLANK1` after `REFRESH_DIV` cycles.
  - `BLANK1` → `DIG0` after `BLANK_CYCLES` cycles.
  - The counter clears on every transition.
- Frame capture: on every `BLANK1`→`DIG0` transition, latch `cap_s1<=s1`, `cap_s2<=s2`, `led<=sum`. Inputs between capture edges are ignored.
- Output per state:
  - `DIG0`: `an=2'b10`, `seg=dec(cap_s1)`.
  - `DIG1`: `an=2'b01`, `seg=dec(cap_s2)`.
  - `BLANK*`: `an=2'b11`, `seg=7'b1111111`.
- Decoder covers full hex 0–F. Required codes:
  - 0 = 1000000
  - 1 = 1111001
  - 3 = 0110000
  - 5 = 0010010
  - 8 = 0000000
  - A = 0001000
  - F = 0001110
- `an` is never `2'b00` in any cycle.
- `sum` is passed through unmodified. No range check; all 32 codes are legal.

## Timing
- Reset values (registered, present the cycle after `reset` is sampled high):
  - `seg=7'b1111111`, `an=2'b11`, `led=5'b00000`.
  - `cap_s1=cap_s2=0`.
  - State `BLANK1`, counter 0.
- After reset deasserts, the first capture occurs after `BLANK_CYCLES` cycles, then `DIG0` begins.
- `seg` and `an` are registered: each reflects the state and captured values of the previous cycle (1-cycle latency). `seg` and `an` change on the same edge.
- Capture-to-`led` latency is 1 cycle.
- Frame length is `2*(REFRESH_DIV+BLANK_CYCLES)` cycles.
- Reset asserted mid-frame: the next edge forces reset values regardless of state or counter. Inputs captured earlier are discarded.
- An input change on the exact capture edge: the value sampled on that edge is taken.

## Configuration
- Macro: `SEVEN_SEG_MUX_BLANK_EN`.
- Defined: four-state FSM as above, with dead-time blanking between digits to suppress ghosting.
- Undefined: `BLANK0`/`BLANK1` do not exist and `BLANK_CYCLES` is unused.
  - FSM alternates `DIG0`↔`DIG1`; frame length is `2*REFRESH_DIV`.
  - Capture happens on `DIG1`→`DIG0`.
  - Reset state is `DIG1` with the counter at `REFRESH_DIV-1`, so the first capture and `DIG0` start one cycle after reset release.
  - Reset output values are unchanged.

## Test plan
All scenarios use `REFRESH_DIV=4`, `BLANK_CYCLES=2`.
- Reset: hold `reset` 3 cycles with `s1=4'h5` → `seg=1111111`, `an=11`, `led=00000` throughout. After release, 2 dark cycles, then `an=10`, `seg=0010010`.
- Steady display (`s1=4'h3`, `s2=4'hA`, `sum=5'b01101`) → repeating 12-cycle pattern:
  - `an=10`/`seg=0110000` ×4
  - dark ×2
  - `an=01`/`seg=0001000` ×4
  - dark ×2
  - `led=01101` held.
- Mid-frame change: change `s2` to `4'hF` during `DIG0` → digit 1 still shows `A` this frame and `F` (`0001110`) only after the next capture.
- Ghost check: over 1000 cycles with random inputs → `an` never `00`, and `seg==1111111` whenever `an==11`.
- Reset mid-`DIG1` with `s1=4'h8`, `s2=4'h1`, `sum=5'b01001` → next cycle all outputs at reset values; post-release first frame shows `8` (`0000000`) then `1` (`1111001`).
- Macro undefined → 8-cycle frame with no dark cycles; `an` alternates `10` ×4, `01` ×4.
